// File: rtl/data_bus_responder.sv
// Single-cycle data-port responder: word RAM plus a small memory-mapped IO block
// (LEDs, seven-segment display, switches, keys, free-running cycle counter).
module data_bus_responder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    input  logic [9:0]  sw,
    input  logic [3:0]  key,
    output logic [9:0]  ledr,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [5:0] OFF_LEDR     = 6'd0;
    localparam logic [5:0] OFF_HEXVAL   = 6'd1;
    localparam logic [5:0] OFF_SW       = 6'd2;
    localparam logic [5:0] OFF_KEY      = 6'd3;
    localparam logic [5:0] OFF_CYCLES   = 6'd4;
    localparam logic [5:0] OFF_HEXBLANK = 6'd5;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Active-low segments, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    logic [31:0] mem [DEPTH];

    logic                  is_io;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [5:0]            io_off;
    logic [31:0]           io_rdata;
    logic [31:0]           wr_merged;

    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic [9:0]  ledr_q, ledr_d;
    logic [23:0] hexval_q, hexval_d;
    logic [5:0]  hexblank_q, hexblank_d;
    logic [31:0] cycles_q, cycles_d;
    logic [9:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [3:0]  key_s1_q, key_s1_d, key_s2_q, key_s2_d;

    assign is_io   = addr[31];
    assign ram_idx = addr[ADDR_WIDTH+1:2];
    assign io_off  = addr[7:2];

    always_comb begin
        case (io_off)
            OFF_LEDR:     io_rdata = {22'd0, ledr_q};
            OFF_HEXVAL:   io_rdata = {8'd0, hexval_q};
            OFF_SW:       io_rdata = {22'd0, sw_s2_q};
            OFF_KEY:      io_rdata = {28'd0, key_s2_q};
            OFF_CYCLES:   io_rdata = cycles_q;
            OFF_HEXBLANK: io_rdata = {26'd0, hexblank_q};
            default:      io_rdata = 32'd0;
        endcase
    end

    // Read-modify-write view of the addressed IO register; truncation drops unimplemented bits.
    assign wr_merged = byte_merge(io_rdata, wdata, wstrb);

    always_comb begin
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        ledr_d        = ledr_q;
        hexval_d      = hexval_q;
        hexblank_d    = hexblank_q;
        cycles_d      = cycles_q + 32'd1;
        sw_s1_d       = sw;
        sw_s2_d       = sw_s1_q;
        key_s1_d      = key;
        key_s2_d      = key_s1_q;
        if (we) begin
            if (is_io) begin
                case (io_off)
                    OFF_LEDR:     ledr_d     = wr_merged[9:0];
                    OFF_HEXVAL:   hexval_d   = wr_merged[23:0];
                    OFF_HEXBLANK: hexblank_d = wr_merged[5:0];
                    default:      ;
                endcase
            end
        end else begin
            rdata_valid_d = 1'b1;
            rdata_d       = is_io ? io_rdata : mem[ram_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            ledr_q        <= 10'd0;
            hexval_q      <= 24'd0;
            hexblank_q    <= 6'd0;
            cycles_q      <= 32'd0;
            sw_s1_q       <= 10'd0;
            sw_s2_q       <= 10'd0;
            key_s1_q      <= 4'd0;
            key_s2_q      <= 4'd0;
        end else begin
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            ledr_q        <= ledr_d;
            hexval_q      <= hexval_d;
            hexblank_q    <= hexblank_d;
            cycles_q      <= cycles_d;
            sw_s1_q       <= sw_s1_d;
            sw_s2_q       <= sw_s2_d;
            key_s1_q      <= key_s1_d;
            key_s2_q      <= key_s2_d;
        end
    end

    // RAM is deliberately left out of reset so its contents survive it.
    always_ff @(posedge clk) begin
        if (we && !is_io) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign ledr        = ledr_q;

    assign hex0 = hexblank_q[0] ? 7'b1111111 : seg7(hexval_q[3:0]);
    assign hex1 = hexblank_q[1] ? 7'b1111111 : seg7(hexval_q[7:4]);
    assign hex2 = hexblank_q[2] ? 7'b1111111 : seg7(hexval_q[11:8]);
    assign hex3 = hexblank_q[3] ? 7'b1111111 : seg7(hexval_q[15:12]);
    assign hex4 = hexblank_q[4] ? 7'b1111111 : seg7(hexval_q[19:16]);
    assign hex5 = hexblank_q[5] ? 7'b1111111 : seg7(hexval_q[23:20]);

    logic unused_bits;
    assign unused_bits = ^{addr[30:8], addr[1:0], wr_merged[31:24]};

endmodule

// File: tb/tb_data_bus_responder.sv
// Randomised bench for data_bus_responder against a map-level model of the RAM and IO registers.
module tb_data_bus_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [9:0]  sw;
    logic [3:0]  key;
    logic [9:0]  ledr;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0]  hex_all [6];

    data_bus_responder #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .we(we), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .rdata_valid(rdata_valid), .sw(sw), .key(key), .ledr(ledr),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clk = ~clk;

    always_comb begin
        hex_all[0] = hex0; hex_all[1] = hex1; hex_all[2] = hex2;
        hex_all[3] = hex3; hex_all[4] = hex4; hex_all[5] = hex5;
    end

    // Reference cycle count: zero in reset, +1 on every edge afterwards.
    int unsigned tb_cyc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cyc <= 0;
        else          tb_cyc <= tb_cyc + 1;
    end

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic [31:0] ref_mem [int];
    logic [31:0] m_ledr, m_hexval, m_hexblank, m_sw, m_key;
    logic [31:0] exp_rdata;
    logic        exp_valid;
    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx;
        idx = int'(a[11:2]);
        if (!a[31]) return ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
        case (a[7:2])
            6'd0:    return m_ledr;
            6'd1:    return m_hexval;
            6'd2:    return m_sw;
            6'd3:    return m_key;
            6'd4:    return tb_cyc;
            6'd5:    return m_hexblank;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [6:0] hex_exp(input int k);
        return m_hexblank[k] ? 7'b1111111 : glyph[m_hexval[4*k +: 4]];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a[11:2]);
        if (!a[31]) begin
            ref_mem[idx] = merge(ref_mem.exists(idx) ? ref_mem[idx] : 32'd0, d, s);
        end else begin
            case (a[7:2])
                6'd0:    m_ledr     = merge(m_ledr, d, s) & 32'h3FF;
                6'd1:    m_hexval   = merge(m_hexval, d, s) & 32'hFFFFFF;
                6'd5:    m_hexblank = merge(m_hexblank, d, s) & 32'h3F;
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        m_ledr = 0; m_hexval = 0; m_hexblank = 0; exp_rdata = 0; exp_valid = 0;
    endtask

    // One bus cycle: drive after the falling edge, predict, sample 1 ns after the rising edge.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        we = w; addr = a; wdata = d; wstrb = s;
        if (w) begin
            exp_valid = 1'b0;
            model_write(a, d, s);
        end else begin
            exp_valid = 1'b1;
            exp_rdata = model_read(a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) access(1'b1, 32'd0, 32'd0, 4'b0000);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; we = 1'b1; addr = 0; wdata = 0; wstrb = 0; sw = 0; key = 4'hF;
        m_sw = 0; m_key = 4'hF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata); end
        n_vec++; if (rdata_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", rdata_valid); end
        n_vec++; if (ledr !== 10'd0) begin n_err++; $display("FAIL reset_ledr got %h want 0", ledr); end
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (hex_all[k] !== 7'b1000000) begin n_err++; $display("FAIL reset_hex%0d got %b want 1000000", k, hex_all[k]); end
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_vec++; if (rdata_valid !== 1'b0) begin n_err++; $display("FAIL release_valid got %b want 0", rdata_valid); end
    endtask

    task automatic test_ram_strobe();
        access(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
        n_vec++; if (rdata_valid !== 1'b0) begin n_err++; $display("FAIL wr_valid got %b want 0", rdata_valid); end
        access(1'b1, 32'h10, 32'h00001200, 4'b0010);
        access(1'b1, 32'h10, 32'h00000000, 4'b0000);
        access(1'b0, 32'h10, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'hDEAD12EF) begin n_err++; $display("FAIL ram_strobe got %h want DEAD12EF", rdata); end
        n_vec++; if (rdata_valid !== 1'b1) begin n_err++; $display("FAIL ram_valid got %b want 1", rdata_valid); end
        access(1'b1, 32'h20, 32'h5555AAAA, 4'b1111);
        n_vec++; if (rdata !== 32'hDEAD12EF) begin n_err++; $display("FAIL wr_hold got %h want DEAD12EF", rdata); end
        access(1'b0, 32'h7FF0_1013, 32'h0, 4'b0000);
        n_vec++; if (rdata !== exp_rdata) begin n_err++; $display("FAIL ram_alias got %h want %h", rdata, exp_rdata); end
    endtask

    task automatic test_io_regs();
        access(1'b1, 32'h80000000, 32'h3FF, 4'b1111);
        n_vec++; if (ledr !== 10'h3FF) begin n_err++; $display("FAIL ledr_out got %h want 3FF", ledr); end
        access(1'b0, 32'h80000000, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'h3FF) begin n_err++; $display("FAIL ledr_rd got %h want 3FF", rdata); end
        access(1'b1, 32'h80000000, 32'hFFFFFFFF, 4'b1111);
        access(1'b0, 32'h80000000, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'h3FF) begin n_err++; $display("FAIL ledr_mask got %h want 3FF", rdata); end
        access(1'b1, 32'h80000000, 32'h0, 4'b0010);
        access(1'b0, 32'h80000000, 32'h0, 4'b0000);
        n_vec++; if (rdata !== exp_rdata) begin n_err++; $display("FAIL ledr_strb got %h want %h", rdata, exp_rdata); end
        access(1'b1, 32'h8000001C, 32'h1234, 4'b1111);
        access(1'b0, 32'h8000001C, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL unmapped got %h want 0", rdata); end
    endtask

    task automatic test_hex();
        access(1'b1, 32'h80000004, 32'h00ABCDEF, 4'b1111);
        access(1'b1, 32'h80000014, 32'h21, 4'b1111);
        n_vec++; if (hex0 !== 7'b1111111) begin n_err++; $display("FAIL hex0_blank got %b want 1111111", hex0); end
        n_vec++; if (hex1 !== 7'b0000110) begin n_err++; $display("FAIL hex1_E got %b want 0000110", hex1); end
        n_vec++; if (hex2 !== 7'b0100001) begin n_err++; $display("FAIL hex2_D got %b want 0100001", hex2); end
        n_vec++; if (hex3 !== 7'b1000110) begin n_err++; $display("FAIL hex3_C got %b want 1000110", hex3); end
        n_vec++; if (hex4 !== 7'b0000011) begin n_err++; $display("FAIL hex4_B got %b want 0000011", hex4); end
        n_vec++; if (hex5 !== 7'b1111111) begin n_err++; $display("FAIL hex5_blank got %b want 1111111", hex5); end
        access(1'b1, 32'h80000014, 32'hFFFFFFC0, 4'b1111);
        n_vec++; if (hex5 !== 7'b0001000) begin n_err++; $display("FAIL hex5_A got %b want 0001000", hex5); end
        n_vec++; if (hex0 !== 7'b0001110) begin n_err++; $display("FAIL hex0_F got %b want 0001110", hex0); end
        access(1'b0, 32'h80000014, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL hexblank_rd got %h want 0", rdata); end
        access(1'b0, 32'h80000004, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'h00ABCDEF) begin n_err++; $display("FAIL hexval_rd got %h want 00ABCDEF", rdata); end
    endtask

    task automatic test_sw_key();
        @(negedge clk);
        sw = 10'h155; key = 4'b0110; m_sw = 32'h155; m_key = 32'h6;
        idle(2);
        access(1'b0, 32'h80000008, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'h155) begin n_err++; $display("FAIL sw_rd got %h want 155", rdata); end
        access(1'b0, 32'h8000000C, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'h6) begin n_err++; $display("FAIL key_rd got %h want 6", rdata); end
        access(1'b1, 32'h80000008, 32'hFFFFFFFF, 4'b1111);
        access(1'b0, 32'h80000008, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'h155) begin n_err++; $display("FAIL sw_ro got %h want 155", rdata); end
        access(1'b0, 32'h8000001C, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL off7_rd got %h want 0", rdata); end
        access(1'b0, 32'h800000FC, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL off63_rd got %h want 0", rdata); end
    endtask

    task automatic test_cycles();
        logic [31:0] r1, r2;
        access(1'b0, 32'h80000010, 32'h0, 4'b0000);
        r1 = rdata;
        n_vec++; if (r1 !== exp_rdata) begin n_err++; $display("FAIL cycles_val got %h want %h", r1, exp_rdata); end
        idle(9);
        access(1'b1, 32'h80000010, 32'h0, 4'b1111);
        access(1'b0, 32'h80000010, 32'h0, 4'b0000);
        r2 = rdata;
        n_vec++; if (r2 - r1 !== 32'd11) begin n_err++; $display("FAIL cycles_diff got %0d want 11", r2 - r1); end
        n_vec++; if (r2 !== exp_rdata) begin n_err++; $display("FAIL cycles_val2 got %h want %h", r2, exp_rdata); end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic [5:0]  off;
        for (int i = 8; i < 24; i++) access(1'b1, 32'(i) << 2, $urandom, 4'b1111);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 6) begin
                a = {1'b0, 19'($urandom), 10'(8 + $urandom_range(0, 15)), 2'($urandom)};
            end else begin
                off = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
                a = {1'b1, 23'($urandom), off, 2'($urandom)};
            end
            d = $urandom;
            access(1'($urandom), a, d, 4'($urandom));
            n_vec++; if (rdata_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid n=%0d got %b want %b", n, rdata_valid, exp_valid); end
            n_vec++; if (rdata !== exp_rdata) begin n_err++; $display("FAIL rnd_rdata n=%0d addr=%h got %h want %h", n, a, rdata, exp_rdata); end
            n_vec++; if (ledr !== m_ledr[9:0]) begin n_err++; $display("FAIL rnd_ledr n=%0d got %h want %h", n, ledr, m_ledr[9:0]); end
            for (int k = 0; k < 6; k++) begin
                n_vec++;
                if (hex_all[k] !== hex_exp(k)) begin n_err++; $display("FAIL rnd_hex%0d n=%0d got %b want %b", k, n, hex_all[k], hex_exp(k)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        access(1'b1, 32'h80, 32'h11223344, 4'b1111);
        access(1'b0, 32'h80, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'h11223344) begin n_err++; $display("FAIL raw1 got %h want 11223344", rdata); end
        access(1'b1, 32'h80, 32'hAABBCCDD, 4'b1001);
        access(1'b0, 32'h80, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'hAA2233DD) begin n_err++; $display("FAIL raw2 got %h want AA2233DD", rdata); end
        access(1'b0, 32'h10, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'hDEAD12EF || rdata_valid !== 1'b1) begin n_err++; $display("FAIL rr1 got %h/%b want DEAD12EF/1", rdata, rdata_valid); end
        access(1'b0, 32'h80, 32'h0, 4'b0000);
        n_vec++; if (rdata !== exp_rdata || rdata_valid !== 1'b1) begin n_err++; $display("FAIL rr2 got %h/%b want %h/1", rdata, rdata_valid, exp_rdata); end
    endtask

    task automatic test_cycles_wrap();
        @(negedge clk);
        force dut.cycles_q = 32'hFFFFFFFF;
        we = 1'b0; addr = 32'h80000010; wdata = 0; wstrb = 0;
        #1;
        n_vec++; if (dut.cycles_d !== 32'd0) begin n_err++; $display("FAIL cycles_wrap got %h want 0", dut.cycles_d); end
        @(posedge clk);
        #1;
        n_vec++; if (rdata !== 32'hFFFFFFFF) begin n_err++; $display("FAIL cycles_max got %h want FFFFFFFF", rdata); end
        @(negedge clk);
        release dut.cycles_q;
        we = 1'b1; addr = 0; wstrb = 0;
        exp_rdata = 32'hFFFFFFFF; exp_valid = 1'b0;
    endtask

    task automatic test_reset_midop();
        access(1'b0, 32'h10, 32'h0, 4'b0000);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_vec++; if (rdata_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", rdata_valid); end
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata got %h want 0", rdata); end
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (hex_all[k] !== 7'b1000000) begin n_err++; $display("FAIL rst_hex%0d got %b want 1000000", k, hex_all[k]); end
        end
        @(negedge clk);
        we = 1'b0; addr = 32'h10;
        @(posedge clk);
        #1;
        n_vec++; if (rdata_valid !== 1'b0) begin n_err++; $display("FAIL rst_abort got %b want 0", rdata_valid); end
        @(negedge clk);
        reset_n = 1'b1; we = 1'b1; wstrb = 0; addr = 0;
        #1;
        n_vec++; if (rdata_valid !== 1'b0) begin n_err++; $display("FAIL rel_valid got %b want 0", rdata_valid); end
        access(1'b0, 32'h10, 32'h0, 4'b0000);
        n_vec++; if (rdata !== 32'hDEAD12EF || rdata_valid !== 1'b1) begin n_err++; $display("FAIL ram_kept got %h/%b want DEAD12EF/1", rdata, rdata_valid); end
    endtask

    initial begin
        test_reset();
        test_ram_strobe();
        test_io_regs();
        test_hex();
        test_sw_key();
        test_cycles();
        test_random();
        test_back_to_back();
        test_cycles_wrap();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached, vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

endmodule
